// File: rtl/tero_meas_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tero_meas_ctrl
// Purpose  : Scans an array of TERO loops. For each loop it clears the edge
//            counter, lets the loop settle, counts synchronised rising edges
//            of the oscillator over a fixed window and hands the count to a
//            valid/ready consumer before advancing the loop selector.
// Options  : TERO_MEAS_OVF_FLAG_EN - counter saturates instead of wrapping
//            and the result_ovf_o port reports saturation in the window.
// Revision : 1.0 - initial release
// ============================================================================
module tero_meas_ctrl #(
    parameter int NUM_LOOPS     = 32,
    parameter int WINDOW_CYCLES = 1024,
    parameter int SETTLE_CYCLES = 4,
    parameter int CNT_BITS      = 16
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic                         start_i,
    input  logic [$clog2(NUM_LOOPS-1):0] tero_sel_i,
    input  logic                         sel_done_i,
    input  logic                         tero_osc_i,
    output logic                         sel_reset_o,
    output logic                         increment_o,
    output logic                         tero_en_o,
    output logic                         result_valid_o,
    input  logic                         result_ready_i,
    output logic [CNT_BITS-1:0]          result_data_o,
    output logic [$clog2(NUM_LOOPS-1):0] result_idx_o,
    output logic                         busy_o,
    output logic                         scan_done_o
`ifdef TERO_MEAS_OVF_FLAG_EN
    ,
    output logic                         result_ovf_o
`endif
);

    localparam int IDX_W = $clog2(NUM_LOOPS-1) + 1;
    localparam int SET_W = $clog2(SETTLE_CYCLES) + 1;
    localparam int WIN_W = $clog2(WINDOW_CYCLES) + 1;
    localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);
    localparam logic [WIN_W-1:0] WINDOW_LAST = WIN_W'(WINDOW_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CLEAR   = 3'd1,
        S_ARM     = 3'd2,
        S_MEASURE = 3'd3,
        S_RESULT  = 3'd4,
        S_ADVANCE = 3'd5,
        S_DONE    = 3'd6
    } state_t;

    state_t              state_q, state_d;
    logic [SET_W-1:0]    settle_cnt_q;
    logic [WIN_W-1:0]    win_cnt_q;
    logic [CNT_BITS-1:0] edge_cnt_q;
    logic [IDX_W-1:0]    idx_q;
    logic                sync1_q, sync2_q, prev_q;
    logic                w_rise;
    logic                w_settle_last;
    logic                w_win_last;

    assign w_rise        = sync2_q & ~prev_q;
    assign w_settle_last = (settle_cnt_q == SETTLE_LAST);
    assign w_win_last    = (win_cnt_q == WINDOW_LAST);

    // State register
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and state-decoded control outputs
    always_comb begin
        state_d        = state_q;
        sel_reset_o    = 1'b0;
        increment_o    = 1'b0;
        tero_en_o      = 1'b0;
        result_valid_o = 1'b0;
        busy_o         = 1'b1;
        scan_done_o    = 1'b0;
        case (state_q)
            S_IDLE: begin
                busy_o = 1'b0;
                if (start_i) state_d = S_CLEAR;
            end
            S_CLEAR: begin
                sel_reset_o = 1'b1;
                state_d     = S_ARM;
            end
            S_ARM: begin
                tero_en_o = 1'b1;
                if (w_settle_last) state_d = S_MEASURE;
            end
            S_MEASURE: begin
                tero_en_o = 1'b1;
                if (w_win_last) state_d = S_RESULT;
            end
            S_RESULT: begin
                result_valid_o = 1'b1;
                if (result_ready_i) state_d = sel_done_i ? S_DONE : S_ADVANCE;
            end
            S_ADVANCE: begin
                increment_o = 1'b1;
                state_d     = S_ARM;
            end
            S_DONE: begin
                busy_o      = 1'b0;
                scan_done_o = 1'b1;
                if (start_i) state_d = S_CLEAR;
            end
            default: begin
                busy_o  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // Settle and window timers run only in their own state, so each entry starts at zero
    always_ff @(posedge clk_i) begin
        if (reset_i || state_q != S_ARM) begin
            settle_cnt_q <= '0;
        end else begin
            settle_cnt_q <= settle_cnt_q + SET_W'(1);
        end
        if (reset_i || state_q != S_MEASURE) begin
            win_cnt_q <= '0;
        end else begin
            win_cnt_q <= win_cnt_q + WIN_W'(1);
        end
    end

    // Two-flop synchroniser for the asynchronous oscillator plus previous-sample flop
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= tero_osc_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

`ifdef TERO_MEAS_OVF_FLAG_EN
    localparam logic [CNT_BITS-1:0] CNT_MAX = {CNT_BITS{1'b1}};
    logic ovf_q;

    // Edge counter: cleared while arming, saturates on overflow and remembers it
    always_ff @(posedge clk_i) begin
        if (reset_i || state_q == S_ARM) begin
            edge_cnt_q <= '0;
            ovf_q      <= 1'b0;
        end else if (state_q == S_MEASURE && w_rise) begin
            if (edge_cnt_q == CNT_MAX) begin
                ovf_q <= 1'b1;
            end else begin
                edge_cnt_q <= edge_cnt_q + CNT_BITS'(1);
            end
        end
    end

    assign result_ovf_o = ovf_q & result_valid_o;
`else
    // Edge counter: cleared while arming, wraps modulo 2^CNT_BITS
    always_ff @(posedge clk_i) begin
        if (reset_i || state_q == S_ARM) begin
            edge_cnt_q <= '0;
        end else if (state_q == S_MEASURE && w_rise) begin
            edge_cnt_q <= edge_cnt_q + CNT_BITS'(1);
        end
    end
`endif

    // Capture the selected loop index on the last window cycle so it tags the result
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            idx_q <= '0;
        end else if (state_q == S_MEASURE && w_win_last) begin
            idx_q <= tero_sel_i;
        end
    end

    assign result_data_o = edge_cnt_q;
    assign result_idx_o  = idx_q;

endmodule
`default_nettype wire

// File: tb/tb_tero_meas_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_tero_meas_ctrl
// Purpose  : Directed, table-driven bench for tero_meas_ctrl with a simple
//            loop-selector model; a second small instance covers counter
//            wrap / saturation (TERO_MEAS_OVF_FLAG_EN).
// Revision : 1.0 - initial release
// ============================================================================
module tb_tero_meas_ctrl;

    localparam int SET = 2;
    localparam int WIN = 16;

    typedef struct {
        logic        osc_on;
        int          stall;
        logic        start_in_meas;
        logic [15:0] exp_data;
    } vec_t;

    logic        clk;
    logic        reset;
    logic        start;
    logic        ready;
    logic        osc_on;
    logic        osc1;
    logic [2:0]  sel_q = 3'd0;
    logic        sel_done;
    logic        sel_reset_o, increment_o, tero_en_o, result_valid_o;
    logic        busy_o, scan_done_o;
    logic [15:0] result_data_o;
    logic [2:0]  result_idx_o;

    logic        start2;
    logic        osc2;
    logic        sel_reset2, increment2, tero_en2, valid2, busy2, done2;
    logic [2:0]  data2;
    logic [2:0]  idx2;
`ifdef TERO_MEAS_OVF_FLAG_EN
    logic        ovf1, ovf2;
`endif

    int n_vec = 0;
    int n_bad = 0;

    tero_meas_ctrl #(
        .NUM_LOOPS(4), .WINDOW_CYCLES(WIN), .SETTLE_CYCLES(SET), .CNT_BITS(16)
    ) u_dut (
        .clk_i(clk), .reset_i(reset), .start_i(start),
        .tero_sel_i(sel_q), .sel_done_i(sel_done), .tero_osc_i(osc1),
        .sel_reset_o(sel_reset_o), .increment_o(increment_o), .tero_en_o(tero_en_o),
        .result_valid_o(result_valid_o), .result_ready_i(ready),
        .result_data_o(result_data_o), .result_idx_o(result_idx_o),
        .busy_o(busy_o), .scan_done_o(scan_done_o)
`ifdef TERO_MEAS_OVF_FLAG_EN
        , .result_ovf_o(ovf1)
`endif
    );

    tero_meas_ctrl #(
        .NUM_LOOPS(4), .WINDOW_CYCLES(32), .SETTLE_CYCLES(2), .CNT_BITS(3)
    ) u_dut_small (
        .clk_i(clk), .reset_i(reset), .start_i(start2),
        .tero_sel_i(3'd0), .sel_done_i(1'b1), .tero_osc_i(osc2),
        .sel_reset_o(sel_reset2), .increment_o(increment2), .tero_en_o(tero_en2),
        .result_valid_o(valid2), .result_ready_i(1'b1),
        .result_data_o(data2), .result_idx_o(idx2),
        .busy_o(busy2), .scan_done_o(done2)
`ifdef TERO_MEAS_OVF_FLAG_EN
        , .result_ovf_o(ovf2)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Loop selector model: cleared by sel_reset, advanced by increment
    always_ff @(posedge clk) begin
        if (sel_reset_o) sel_q <= 3'd0;
        else if (increment_o) sel_q <= sel_q + 3'd1;
    end
    assign sel_done = (sel_q == 3'd3);

    // Oscillator for the main instance: toggles every 2 clocks when enabled
    initial begin
        osc1 = 1'b0;
        forever begin
            repeat (2) @(negedge clk);
            osc1 = osc_on ? ~osc1 : 1'b0;
        end
    end

    // Oscillator for the small instance: rising edge every 2 clocks
    initial begin
        osc2 = 1'b0;
        forever begin
            @(negedge clk);
            osc2 = ~osc2;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic run_scan(input vec_t v);
        int          nres, ninc, nsr, run, stall_left, cyc;
        logic        done, snap_ok;
        logic [15:0] snap_d;
        logic [2:0]  snap_i;
        nres = 0; ninc = 0; nsr = 0; run = 0; cyc = 0;
        stall_left = v.stall; done = 1'b0; snap_ok = 1'b0;
        snap_d = '0; snap_i = '0;
        osc_on = v.osc_on;
        repeat (4) @(negedge clk);
        ready = (v.stall == 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (!done && cyc < 1000) begin
            if (sel_reset_o) nsr++;
            if (increment_o) ninc++;
            if (tero_en_o) begin
                run++;
            end else if (run != 0) begin
                check("en_len", run, SET + WIN);
                run = 0;
            end
            start = v.start_in_meas && tero_en_o && (run == SET + 3) && (nres == 1);
            if (result_valid_o && stall_left > 0) begin
                if (!snap_ok) begin
                    snap_d = result_data_o;
                    snap_i = result_idx_o;
                    snap_ok = 1'b1;
                end else begin
                    check("stall_data", result_data_o, snap_d);
                    check("stall_idx", result_idx_o, snap_i);
                end
                check("stall_no_inc", ninc, 0);
                stall_left--;
                if (stall_left == 0) ready = 1'b1;
            end
            if (result_valid_o && ready) begin
                check("res_data", result_data_o, v.exp_data);
                check("res_idx", result_idx_o, nres);
`ifdef TERO_MEAS_OVF_FLAG_EN
                check("res_ovf", ovf1, 0);
`endif
                nres++;
            end
            if (scan_done_o) begin
                done = 1'b1;
            end else begin
                @(negedge clk);
                cyc++;
            end
        end
        start = 1'b0;
        check("scan_finished", done, 1);
        check("num_results", nres, 4);
        check("num_increments", ninc, 3);
        check("sel_reset_cycles", nsr, 1);
        check("busy_at_done", busy_o, 0);
        ready = 1'b1;
    endtask

    vec_t vecs[4];

    initial begin
        int   run, cyc;
        logic found;

        // {osc_on, stall cycles at first result, start pulse in MEASURE, expected count}
        vecs[0] = '{1'b1, 0,  1'b0, 16'd4};
        vecs[1] = '{1'b0, 0,  1'b1, 16'd0};
        vecs[2] = '{1'b1, 10, 1'b0, 16'd4};
        vecs[3] = '{1'b1, 0,  1'b0, 16'd4};

        reset = 1'b1; start = 1'b0; start2 = 1'b0; ready = 1'b1; osc_on = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_tero_en", tero_en_o, 0);
        check("rst_sel_reset", sel_reset_o, 0);
        check("rst_increment", increment_o, 0);
        check("rst_valid", result_valid_o, 0);
        check("rst_data", result_data_o, 0);
        check("rst_idx", result_idx_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_scan_done", scan_done_o, 0);
        reset = 1'b0;
        @(negedge clk);
        check("idle_busy", busy_o, 0);

        // Table scans; later entries start from DONE
        for (int i = 0; i < 4; i++) begin
            run_scan(vecs[i]);
        end

        // Reset in the 5th MEASURE cycle of loop 2
        osc_on = 1'b1; ready = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        run = 0; cyc = 0; found = 1'b0;
        while (!found && cyc < 500) begin
            if (tero_en_o && sel_q == 3'd2) run++;
            if (run == SET + 5) found = 1'b1;
            else begin
                @(negedge clk);
                cyc++;
            end
        end
        check("reach_loop2_measure", found, 1);
        reset = 1'b1;
        @(negedge clk);
        check("midmeas_rst_en", tero_en_o, 0);
        check("midmeas_rst_valid", result_valid_o, 0);
        check("midmeas_rst_busy", busy_o, 0);
        reset = 1'b0;
        run_scan(vecs[0]);

        // Reset while a result is pending discards it
        ready = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (!result_valid_o && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check("pending_result_seen", result_valid_o, 1);
        reset = 1'b1;
        @(negedge clk);
        check("midres_rst_valid", result_valid_o, 0);
        check("midres_rst_data", result_data_o, 0);
        check("midres_rst_idx", result_idx_o, 0);
        reset = 1'b0;
        ready = 1'b1;
        @(negedge clk);
        check("midres_idle", busy_o, 0);

        // Small counter: 16 edges into a 3-bit counter
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        cyc = 0;
        while (!valid2 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check("small_valid", valid2, 1);
`ifdef TERO_MEAS_OVF_FLAG_EN
        check("small_sat_data", data2, 7);
        check("small_ovf", ovf2, 1);
`else
        check("small_wrap_data", data2, 0);
`endif
        @(negedge clk);
        check("small_done", done2, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tero_meas_ctrl.md
TERO_MEAS_CTRL -- requirements
Module: tero_meas_ctrl

Interface
REQ-001 Parameter NUM_LOOPS, default 32: number of TERO loops in the array.
REQ-002 Parameter WINDOW_CYCLES, default 1024: measurement window length, clk cycles.
REQ-003 Parameter SETTLE_CYCLES, default 4: cycles TERO is enabled before counting starts; minimum 2.
REQ-004 Parameter CNT_BITS, default 16: width of oscillation counter.
REQ-005 clk  input  1  system clock, all logic on rising edge.
REQ-006 reset  input  1  reset, synchronous, active-high.
REQ-007 start  input  1  begin a full scan of all loops; sampled in IDLE or DONE only.
REQ-008 tero_sel  input  $clog2(NUM_LOOPS-1)+1  index of currently selected loop, from loop selector.
REQ-009 sel_done  input  1  selector reports last loop currently selected.
REQ-010 tero_osc  input  1  muxed oscillator output of selected loop, asynchronous to clk.
REQ-011 sel_reset  output  1  one-cycle pulse clearing the selector to loop 0.
REQ-012 increment  output  1  one-cycle pulse advancing the selector.
REQ-013 tero_en  output  1  enables the selected loop.
REQ-014 result_valid  output  1  result_data/result_idx valid.
REQ-015 result_ready  input  1  consumer accepts result when high with result_valid.
REQ-016 result_data  output  CNT_BITS  rising-edge count of the measured loop.
REQ-017 result_idx  output  width of tero_sel  loop index belonging to result_data.
REQ-018 busy  output  1  high in every state except IDLE and DONE.
REQ-019 scan_done  output  1  high while in DONE.

Function
REQ-020 FSM states IDLE, CLEAR, ARM, MEASURE, RESULT, ADVANCE, DONE; busy, scan_done, tero_en, sel_reset, increment, result_valid decoded from state only.
REQ-021 IDLE/DONE + start=1 -> CLEAR; start ignored in all other states.
REQ-022 CLEAR: sel_reset=1 for exactly one cycle -> ARM.
REQ-023 ARM: tero_en=1, counter cleared to 0, SETTLE_CYCLES cycles -> MEASURE.
REQ-024 MEASURE: tero_en=1, WINDOW_CYCLES cycles, counter +1 per detected rising edge -> RESULT.
REQ-025 tero_osc passes a 2-flop synchronizer; rising edge = sync output 1 while previous sample 0; only edges detected in MEASURE cycles are counted.
REQ-026 RESULT: tero_en=0, result_valid=1, result_data=final count, result_idx=tero_sel captured at MEASURE exit; all held stable until result_valid&&result_ready.
REQ-027 On RESULT handshake: sel_done=1 -> DONE; else -> ADVANCE.
REQ-028 ADVANCE: increment=1 for exactly one cycle -> ARM; exactly one increment per non-last loop.
REQ-029 A full scan delivers exactly NUM_LOOPS results, indices 0..NUM_LOOPS-1 in order.
REQ-030 result_ready=1 in the RESULT entry cycle completes the handshake that cycle (zero-wait).
REQ-031 Window and settle counters sized $clog2(max)+1 bits; no off-by-one: ARM lasts exactly SETTLE_CYCLES, MEASURE exactly WINDOW_CYCLES.
REQ-032 Without overflow feature, counter wraps modulo 2^CNT_BITS.

Reset
REQ-033 reset=1 forces IDLE at next edge from any state, including mid-MEASURE and mid-RESULT.
REQ-034 Reset values: tero_en=0, sel_reset=0, increment=0, result_valid=0, result_data=0, result_idx=0, busy=0, scan_done=0, counters and synchronizer flops 0.
REQ-035 A pending result is discarded by reset; no handshake completes in the reset cycle.

Configuration
REQ-036 Macro TERO_MEAS_OVF_FLAG_EN defined: counter saturates at 2^CNT_BITS-1, extra output result_ovf (1 bit) high with result_valid when saturation occurred during that window, reset 0.
REQ-037 Macro undefined: no result_ovf port, counter wraps per REQ-032.

Verification
REQ-038 NUM_LOOPS=4, WINDOW=16, SETTLE=2, tero_osc toggling every 2 clk, result_ready=1 -> 4 results, idx 0,1,2,3, data 4 each (±1), 3 increment pulses, scan_done=1.
REQ-039 Same, result_ready held 0 for 10 cycles at first result -> result_valid, data, idx stable 10 cycles, no increment until accept.
REQ-040 tero_osc constant 0 -> all result_data=0; start asserted during MEASURE -> ignored, sequence unchanged.
REQ-041 reset asserted in 5th MEASURE cycle of loop 2 -> next cycle IDLE, tero_en=0, result_valid=0; subsequent start -> sel_reset pulse, scan restarts at idx 0.
REQ-042 CNT_BITS=3, WINDOW=32, edge every 2 clk: macro on -> data 7, result_ovf=1; macro off -> data 16 mod 8 = 0.
REQ-043 From DONE, start=1 -> CLEAR, sel_reset pulse, second full scan identical to first.
